// File: rtl/piso_serializer_if.sv
// piso_serializer_if: load handshake and serial stream signals of the PISO transmitter
//   load_valid/load_data/load_ready : producer word handshake
//   shift_en                        : bit-rate strobe
//   serial_out/serial_valid         : MSB-first bit stream
//   frame_start/frame_done/busy     : framing and activity status
interface piso_serializer_if #(parameter int N = 8);
  logic         load_valid;
  logic [N-1:0] load_data;
  logic         load_ready;
  logic         shift_en;
  logic         serial_out;
  logic         serial_valid;
  logic         frame_start;
  logic         frame_done;
  logic         busy;
  modport master (
    output load_valid, load_data, shift_en,
    input  load_ready, serial_out, serial_valid, frame_start, frame_done, busy
  );
  modport slave (
    input  load_valid, load_data, shift_en,
    output load_ready, serial_out, serial_valid, frame_start, frame_done, busy
  );
endinterface

// File: rtl/piso_serializer.sv
// piso_serializer: N-bit parallel-in, MSB-first serial-out transmitter with one-word holding register
//   clock   : rising-edge clock
//   reset_n : asynchronous active-low reset
//   bus     : load handshake, shift strobe and serial outputs (piso_serializer_if.slave)
module piso_serializer #(
  parameter int N = 8
) (
  input  logic               clock,
  input  logic               reset_n,
  piso_serializer_if.slave   bus
);
  localparam int CW = $clog2(N);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t        state, state_nx;
  logic [N-1:0]  hold, shreg;
  logic          hold_full, done_q;
  logic [CW-1:0] bit_cnt;
  logic          accept, last, reload;
  assign accept = bus.load_valid && !hold_full;
  assign last   = (state == SHIFT) && bus.shift_en && (bit_cnt == CW'(N - 1));
  // reload happens from IDLE or seamlessly on the last bit's edge when a word is queued
  assign reload = hold_full && ((state == IDLE) || last);
  always_comb begin
    state_nx = state;
    state_nx = (state == IDLE) ? (hold_full ? SHIFT : IDLE) : ((last && !hold_full) ? IDLE : SHIFT);
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      hold      <= '0;
      hold_full <= 1'b0;
      shreg     <= '0;
      bit_cnt   <= '0;
      done_q    <= 1'b0;
    end else begin
      state  <= state_nx;
      done_q <= last;
      if (accept) begin
        hold      <= bus.load_data;
        hold_full <= 1'b1;
      end else if (reload) begin
        hold_full <= 1'b0;
      end
      if (reload) begin
        shreg   <= hold;
        bit_cnt <= '0;
      end else if (state == SHIFT && bus.shift_en) begin
        shreg   <= {shreg[N-2:0], 1'b0};
        bit_cnt <= bit_cnt + CW'(1);
      end
    end
  end
  assign bus.load_ready   = !hold_full;
  assign bus.serial_out   = (state == SHIFT) && shreg[N-1];
  assign bus.serial_valid = (state == SHIFT);
  assign bus.frame_start  = (state == SHIFT) && (bit_cnt == '0);
  assign bus.frame_done   = done_q;
  assign bus.busy         = (state == SHIFT) || hold_full;
endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: directed self-checking bench for piso_serializer (N=8)
module tb_piso_serializer;
  logic clock = 1'b0;
  logic reset_n;
  int checks = 0;
  int passes = 0;
  logic [7:0] rx;
  piso_serializer_if #(.N(8)) bus ();
  piso_serializer #(.N(8)) dut (.clock(clock), .reset_n(reset_n), .bus(bus));
  always #5 clock = ~clock;
  always @(posedge clock) if (bus.serial_valid && bus.shift_en) rx <= {rx[6:0], bus.serial_out};
  task automatic tick;
    @(posedge clock);
    #1;
  endtask
  task automatic test_reset;
    reset_n = 1'b0;
    bus.load_valid = 1'b0;
    bus.load_data = 8'h00;
    bus.shift_en = 1'b1;
    #2;
    checks++; if (bus.load_ready !== 1'b1) $display("FAIL reset load_ready: got %b expected 1", bus.load_ready); else passes++;
    checks++; if (bus.serial_out !== 1'b0) $display("FAIL reset serial_out: got %b expected 0", bus.serial_out); else passes++;
    checks++; if (bus.serial_valid !== 1'b0) $display("FAIL reset serial_valid: got %b expected 0", bus.serial_valid); else passes++;
    checks++; if (bus.frame_start !== 1'b0) $display("FAIL reset frame_start: got %b expected 0", bus.frame_start); else passes++;
    checks++; if (bus.frame_done !== 1'b0) $display("FAIL reset frame_done: got %b expected 0", bus.frame_done); else passes++;
    checks++; if (bus.busy !== 1'b0) $display("FAIL reset busy: got %b expected 0", bus.busy); else passes++;
    tick;
    reset_n = 1'b1;
    tick;
  endtask
  task automatic test_single(input logic [7:0] w, input string tag);
    bus.shift_en = 1'b1;
    bus.load_valid = 1'b1;
    bus.load_data = w;
    tick;
    bus.load_valid = 1'b0;
    checks++; if (bus.load_ready !== 1'b0 || bus.serial_valid !== 1'b0 || bus.busy !== 1'b1)
      $display("FAIL %s accepted: ready/valid/busy got %b%b%b expected 001", tag, bus.load_ready, bus.serial_valid, bus.busy); else passes++;
    for (int i = 0; i < 8; i++) begin
      tick;
      checks++; if (bus.serial_out !== w[7-i] || bus.serial_valid !== 1'b1)
        $display("FAIL %s bit%0d: out/valid got %b%b expected %b1", tag, i, bus.serial_out, bus.serial_valid, w[7-i]); else passes++;
      checks++; if (bus.frame_start !== (i == 0))
        $display("FAIL %s frame_start%0d: got %b expected %b", tag, i, bus.frame_start, i == 0); else passes++;
      checks++; if (bus.frame_done !== 1'b0)
        $display("FAIL %s frame_done_early%0d: got %b expected 0", tag, i, bus.frame_done); else passes++;
      if (i == 0) begin
        checks++; if (bus.load_ready !== 1'b1) $display("FAIL %s load_ready_after_reload: got %b expected 1", tag, bus.load_ready); else passes++;
      end
    end
    tick;
    checks++; if (bus.frame_done !== 1'b1) $display("FAIL %s frame_done: got %b expected 1", tag, bus.frame_done); else passes++;
    checks++; if (bus.serial_valid !== 1'b0 || bus.busy !== 1'b0)
      $display("FAIL %s idle_after: valid/busy got %b%b expected 00", tag, bus.serial_valid, bus.busy); else passes++;
    checks++; if (rx !== w) $display("FAIL %s sipo_rx: got %h expected %h", tag, rx, w); else passes++;
    tick;
    checks++; if (bus.frame_done !== 1'b0) $display("FAIL %s frame_done_width: got %b expected 0", tag, bus.frame_done); else passes++;
  endtask
  task automatic test_back_to_back;
    logic [15:0] pat;
    pat = 16'h3CC3;
    bus.shift_en = 1'b1;
    bus.load_valid = 1'b1;
    bus.load_data = 8'h3C;
    tick;
    bus.load_data = 8'hC3;
    for (int c = 0; c < 17; c++) begin
      tick;
      if (c < 16) begin
        checks++; if (bus.serial_out !== pat[15-c] || bus.serial_valid !== 1'b1)
          $display("FAIL b2b bit%0d: out/valid got %b%b expected %b1", c, bus.serial_out, bus.serial_valid, pat[15-c]); else passes++;
        checks++; if (bus.load_ready !== !(c >= 1 && c <= 7))
          $display("FAIL b2b load_ready%0d: got %b expected %b", c, bus.load_ready, !(c >= 1 && c <= 7)); else passes++;
        checks++; if (bus.frame_start !== (c == 0 || c == 8))
          $display("FAIL b2b frame_start%0d: got %b expected %b", c, bus.frame_start, c == 0 || c == 8); else passes++;
      end
      checks++; if (bus.frame_done !== (c == 8 || c == 16))
        $display("FAIL b2b frame_done%0d: got %b expected %b", c, bus.frame_done, c == 8 || c == 16); else passes++;
      if (c == 1) bus.load_valid = 1'b0;
    end
    checks++; if (bus.serial_valid !== 1'b0 || bus.busy !== 1'b0)
      $display("FAIL b2b idle_after: valid/busy got %b%b expected 00", bus.serial_valid, bus.busy); else passes++;
    tick;
  endtask
  task automatic test_throttled;
    logic [7:0] w;
    w = 8'h96;
    bus.shift_en = 1'b0;
    bus.load_valid = 1'b1;
    bus.load_data = w;
    tick;
    bus.load_valid = 1'b0;
    tick;
    for (int b = 0; b < 8; b++) begin
      for (int k = 0; k < 3; k++) begin
        checks++; if (bus.serial_out !== w[7-b] || bus.serial_valid !== 1'b1)
          $display("FAIL thr bit%0d_%0d: out/valid got %b%b expected %b1", b, k, bus.serial_out, bus.serial_valid, w[7-b]); else passes++;
        checks++; if (bus.frame_done !== 1'b0 || bus.frame_start !== (b == 0))
          $display("FAIL thr flags%0d_%0d: done/start got %b%b expected 0%b", b, k, bus.frame_done, bus.frame_start, b == 0); else passes++;
        bus.shift_en = (k == 2);
        tick;
      end
    end
    bus.shift_en = 1'b0;
    checks++; if (bus.frame_done !== 1'b1 || bus.serial_valid !== 1'b0)
      $display("FAIL thr done: done/valid got %b%b expected 10", bus.frame_done, bus.serial_valid); else passes++;
    checks++; if (rx !== w) $display("FAIL thr sipo_rx: got %h expected %h", rx, w); else passes++;
    bus.shift_en = 1'b1;
    tick;
  endtask
  task automatic test_abort;
    bus.shift_en = 1'b1;
    bus.load_valid = 1'b1;
    bus.load_data = 8'hFF;
    tick;
    bus.load_data = 8'h00;
    tick;
    tick;
    bus.load_valid = 1'b0;
    checks++; if (bus.load_ready !== 1'b0) $display("FAIL abort queued: load_ready got %b expected 0", bus.load_ready); else passes++;
    tick;
    tick;
    tick;
    checks++; if (bus.serial_out !== 1'b1 || bus.serial_valid !== 1'b1)
      $display("FAIL abort pre: out/valid got %b%b expected 11", bus.serial_out, bus.serial_valid); else passes++;
    #2 reset_n = 1'b0;
    #1;
    checks++; if (bus.serial_out !== 1'b0 || bus.serial_valid !== 1'b0 || bus.frame_start !== 1'b0)
      $display("FAIL abort outputs: out/valid/start got %b%b%b expected 000", bus.serial_out, bus.serial_valid, bus.frame_start); else passes++;
    checks++; if (bus.busy !== 1'b0 || bus.load_ready !== 1'b1 || bus.frame_done !== 1'b0)
      $display("FAIL abort status: busy/ready/done got %b%b%b expected 010", bus.busy, bus.load_ready, bus.frame_done); else passes++;
    tick;
    tick;
    reset_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      tick;
      checks++; if (bus.serial_valid !== 1'b0 || bus.frame_done !== 1'b0 || bus.busy !== 1'b0)
        $display("FAIL abort quiet%0d: valid/done/busy got %b%b%b expected 000", c, bus.serial_valid, bus.frame_done, bus.busy); else passes++;
    end
    test_single(8'h81, "post_abort");
  endtask
  task automatic test_idle_strobes;
    bus.shift_en = 1'b1;
    bus.load_valid = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick;
      checks++; if (bus.serial_valid !== 1'b0 || bus.serial_out !== 1'b0 || bus.busy !== 1'b0 || bus.frame_done !== 1'b0)
        $display("FAIL idle%0d: valid/out/busy/done got %b%b%b%b expected 0000", c, bus.serial_valid, bus.serial_out, bus.busy, bus.frame_done); else passes++;
    end
  endtask
  initial begin
    test_reset;
    test_single(8'hA5, "single");
    test_back_to_back;
    test_throttled;
    test_abort;
    test_idle_strobes;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/piso_serializer.md
# piso_serializer

Parallel-in, serial-out transmitter that converts N-bit words into an MSB-first bit stream, one bit per `shift_en` strobe. It is the transmit end of the team's serial link; the bit ordering lets the receiving serial-in shift register rebuild the word exactly after N strobes. A one-word holding register with a valid/ready load handshake lets the producer queue the next word while the current one shifts, so words go back-to-back with no idle bit.

## Interface
- `N`, default 8: word width in bits; legal range N ≥ 2.

- `clock`  in  1  rising-edge clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `load_valid`  in  1  producer offers `load_data` this cycle.
- `load_data`  in  N  word to serialize.
- `load_ready`  out  1  holding register is empty; a word is accepted on an edge where `load_valid && load_ready`.
- `shift_en`  in  1  bit-rate strobe; the current bit is consumed on each edge where it is high.
- `serial_out`  out  1  current bit; 0 when idle.
- `serial_valid`  out  1  `serial_out` carries a word bit.
- `frame_start`  out  1  high while the first bit (MSB) of a word is presented.
- `frame_done`  out  1  one-cycle pulse after the last bit of a word is consumed.
- `busy`  out  1  a word is shifting or the holding register is full.

## Operation
- Storage:
  - `hold` (N bits) plus `hold_full`.
  - `shreg` (N bits).
  - `bit_cnt`, sized `$clog2(N)`.
  - State is IDLE or SHIFT.
- `load_ready = !hold_full`. On accept, `hold <= load_data` and `hold_full <= 1`.
- IDLE with `hold_full` = 1: on the next edge, `shreg <= hold`, `hold_full <= 0`, `bit_cnt <= 0`, go to SHIFT.
- SHIFT:
  - `serial_out = shreg[N-1]`. `serial_valid` = 1. `frame_start = (bit_cnt == 0)`.
  - Edge with `shift_en` = 1 and `bit_cnt < N-1`: `shreg <= {shreg[N-2:0], 1'b0}`, `bit_cnt++`.
  - Edge with `shift_en` = 1 and `bit_cnt == N-1` (last bit):
    - If `hold_full`: reload `shreg` from `hold`, clear `hold_full`, set `bit_cnt` to 0, stay in SHIFT. There is no gap bit.
    - Otherwise: go to IDLE.
  - In both cases, `frame_done` is registered high for the following cycle.
  - `shift_en` = 0: everything holds; the bit stays on `serial_out`.
- In IDLE, `serial_out`, `serial_valid` and `frame_start` are 0, and `shift_en` is ignored.
- `busy = (state == SHIFT) || hold_full`.
- An accept and a reload never coincide, because `load_ready` is low whenever `hold` is full.

## Timing
- Reset values (asynchronous, immediate on `reset_n` = 0):
  - state is IDLE; `hold_full`, `shreg`, `hold` and `bit_cnt` are 0.
  - `serial_out`, `serial_valid`, `frame_start`, `frame_done` and `busy` are 0; `load_ready` is 1.
- Reset mid-word aborts the current word and discards `hold`. No `frame_done` is produced for the aborted word.
- Latency: a word accepted at edge E shows its MSB on `serial_out`, with `serial_valid` and `frame_start` high, after edge E+1 (from IDLE). `load_ready` returns high after E+1.
- With `shift_en` held at 1, each word occupies exactly N consecutive cycles. `frame_done` is high in the cycle after the last bit's edge, which is also the first bit cycle of the next word if one is queued.
- Sustained throughput of one word per N strobes requires the producer to refill `hold` within N−1 cycles of a reload.
- `frame_done` is independent of `serial_valid` and may overlap `frame_start`.

## Test plan
- **Reset:** assert `reset_n` = 0 mid-run. All outputs read 0 except `load_ready` = 1, with no clock edge needed.
- **Single word:** N=8, load 0xA5, `shift_en` = 1 constantly.
  - `serial_out` = 1,0,1,0,0,1,0,1 on 8 consecutive cycles starting one cycle after accept.
  - `frame_start` is high on the first bit only; `frame_done` pulses once in the 9th cycle.
  - A looped-back SIPO receiver reads 0xA5.
- **Back-to-back:** hold `load_valid` with 0x3C then 0xC3.
  - 16 contiguous valid bits 0011110011000011, with no gap.
  - `load_ready` is low from the second accept until the reload.
  - Two `frame_done` pulses, 8 cycles apart.
- **Throttled:** `shift_en` high 1 cycle in 3, word 0x96. Each bit is held for 3 cycles, the bit order is unchanged, and `frame_done` follows the 8th strobe.
- **Abort:** pulse `reset_n` low after 4 bits of 0xFF, with 0x00 queued in `hold`.
  - Outputs go to 0 immediately; nothing further is transmitted.
  - After release, loading 0x81 sends 10000001 correctly.
- **Idle strobes:** `shift_en` = 1 with `load_valid` = 0 for 20 cycles. `serial_valid`, `serial_out` and `busy` stay 0, and `frame_done` never pulses.
